// File: rtl/sm83_idu_pkg.sv
// Shared constants for the IDU address register and IE control block.
// Op codes, reset values and the default IE bus address.
package sm83_idu_pkg;

  typedef logic [2:0] idu_op_t;

  localparam idu_op_t IDU_HOLD   = 3'd0;
  localparam idu_op_t IDU_LOAD   = 3'd1;
  localparam idu_op_t IDU_INC    = 3'd2;
  localparam idu_op_t IDU_DEC    = 3'd3;
  localparam idu_op_t IDU_INC_LO = 3'd4;
  localparam idu_op_t IDU_DEC_LO = 3'd5;
  localparam idu_op_t IDU_ADJ    = 3'd6;

  localparam int unsigned RST_ADDR = 0;
  localparam int unsigned RST_IE   = 0;
  localparam logic        RST_WRAP = 1'b0;

  localparam logic [15:0] IE_ADDR_DFLT = 16'hFFFF;

endpackage

// File: rtl/idu_half.sv
// One registered half of the IDU address register.
// Steps only when cin is set; co flags the step leaving the half.
module idu_half #(
  parameter int          W   = 8,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         inc,
  input  logic         dec,
  input  logic         cin,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q,
  output logic         co
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RST;
    end else if (ld) begin
      q <= ld_val;
    end else if (cin && inc) begin
      q <= q + W'(1);
    end else if (cin && dec) begin
      q <= q - W'(1);
    end
  end

  assign co = cin & ((inc & (&q)) | (dec & ~(|q)));

endmodule

// File: rtl/idu_ie_ctrl.sv
// Registered IDU address register with IE register, write decode
// and pending-interrupt vector for the IRQ arbiter.
module idu_ie_ctrl
  import sm83_idu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int HALF_W = ADDR_W / 2,
  parameter int DATA_W = 8,
  parameter int N_IRQ  = 5,
  parameter logic [ADDR_W-1:0] IE_ADDR = ADDR_W'(IE_ADDR_DFLT)
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic [2:0]        idu_op,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              alu_carry,
  input  logic              temp_sign,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_wr,
  input  logic [DATA_W-1:0] bus_data,
  output logic [DATA_W-1:0] ie,
  input  logic [N_IRQ-1:0]  if_in,
  output logic [N_IRQ-1:0]  irq_pending,
  output logic              irq_any
);

  localparam logic [ADDR_W-1:0] ADDR_RST = ADDR_W'(RST_ADDR);

  logic              lo_ld;
  logic              lo_inc;
  logic              lo_dec;
  logic              hi_ld;
  logic              hi_inc;
  logic              hi_dec;
  logic              hi_cin;
  logic              chain;
  logic              wrap_lo;
  logic              wrap_hi;
  logic              lo_co;
  logic              hi_co;
  logic              wrap_d;
  logic [HALF_W-1:0] lo_q;
  logic [HALF_W-1:0] hi_q;
  logic              ie_wr;
  logic [N_IRQ-1:0]  pend_d;

  always_comb begin
    lo_ld   = 1'b0;
    lo_inc  = 1'b0;
    lo_dec  = 1'b0;
    hi_ld   = 1'b0;
    hi_inc  = 1'b0;
    hi_dec  = 1'b0;
    chain   = 1'b0;
    wrap_lo = 1'b0;
    wrap_hi = 1'b0;
    case (idu_op)
      IDU_LOAD: begin
        lo_ld = 1'b1;
        hi_ld = 1'b1;
      end
      IDU_INC: begin
        lo_inc  = 1'b1;
        hi_inc  = 1'b1;
        chain   = 1'b1;
        wrap_hi = 1'b1;
      end
      IDU_DEC: begin
        lo_dec  = 1'b1;
        hi_dec  = 1'b1;
        chain   = 1'b1;
        wrap_hi = 1'b1;
      end
      IDU_INC_LO: begin
        lo_inc  = 1'b1;
        wrap_lo = 1'b1;
      end
      IDU_DEC_LO: begin
        lo_dec  = 1'b1;
        wrap_lo = 1'b1;
      end
      IDU_ADJ: begin
        lo_ld   = 1'b1;
        hi_inc  = alu_carry & ~temp_sign;
        hi_dec  = ~alu_carry & temp_sign;
        wrap_hi = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Carry only ripples into the high half for full-width INC/DEC.
  assign hi_cin = chain ? lo_co : 1'b1;

  idu_half #(
    .W   (HALF_W),
    .RST (ADDR_RST[HALF_W-1:0])
  ) u_lo (
    .clk    (CLK),
    .rst_n  (nRESET),
    .ld     (lo_ld),
    .inc    (lo_inc),
    .dec    (lo_dec),
    .cin    (1'b1),
    .ld_val (load_val[HALF_W-1:0]),
    .q      (lo_q),
    .co     (lo_co)
  );

  idu_half #(
    .W   (HALF_W),
    .RST (ADDR_RST[ADDR_W-1:HALF_W])
  ) u_hi (
    .clk    (CLK),
    .rst_n  (nRESET),
    .ld     (hi_ld),
    .inc    (hi_inc),
    .dec    (hi_dec),
    .cin    (hi_cin),
    .ld_val (load_val[ADDR_W-1:HALF_W]),
    .q      (hi_q),
    .co     (hi_co)
  );

  assign addr   = {hi_q, lo_q};
  assign wrap_d = (wrap_lo & lo_co) | (wrap_hi & hi_co);

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      wrap <= RST_WRAP;
    end else begin
      wrap <= wrap_d;
    end
  end

  assign ie_wr  = bus_wr && (bus_addr == IE_ADDR);
  assign pend_d = ie[N_IRQ-1:0] & if_in;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      ie          <= DATA_W'(RST_IE);
      irq_pending <= '0;
      irq_any     <= 1'b0;
    end else begin
      if (ie_wr) begin
        ie <= bus_data;
      end
      irq_pending <= pend_d;
      irq_any     <= |pend_d;
    end
  end

endmodule

// File: tb/tb_idu_ie_ctrl.sv
// Directed bench for idu_ie_ctrl with a behavioural reference model
// and a per-cycle compare process.
module tb_idu_ie_ctrl;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic [2:0]  idu_op = 3'd0;
  logic [15:0] load_val = '0;
  logic        alu_carry = 1'b0;
  logic        temp_sign = 1'b0;
  logic [15:0] addr;
  logic        wrap;
  logic [15:0] bus_addr = '0;
  logic        bus_wr = 1'b0;
  logic [7:0]  bus_data = '0;
  logic [7:0]  ie;
  logic [4:0]  if_in = '0;
  logic [4:0]  irq_pending;
  logic        irq_any;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  int        m_addr = 0;
  bit        m_wrap = 1'b0;
  int        m_ie = 0;
  int        m_pend = 0;
  bit        m_any = 1'b0;

  idu_ie_ctrl dut (
    .CLK         (CLK),
    .nRESET      (nRESET),
    .idu_op      (idu_op),
    .load_val    (load_val),
    .alu_carry   (alu_carry),
    .temp_sign   (temp_sign),
    .addr        (addr),
    .wrap        (wrap),
    .bus_addr    (bus_addr),
    .bus_wr      (bus_wr),
    .bus_data    (bus_data),
    .ie          (ie),
    .if_in       (if_in),
    .irq_pending (irq_pending),
    .irq_any     (irq_any)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      chk("addr", int'(addr), m_addr);
      chk("wrap", int'(wrap), int'(m_wrap));
      chk("ie", int'(ie), m_ie);
      chk("irq_pending", int'(irq_pending), m_pend);
      chk("irq_any", int'(irq_any), int'(m_any));
    end
  end

  // Advance one clock, computing the model's next state from the spec rules.
  task automatic cyc();
    int na, nie, np, hi, nh, d;
    bit nw;
    na  = m_addr;
    nw  = 1'b0;
    nie = m_ie;
    np  = m_ie & 31 & int'(if_in);
    if (!nRESET) begin
      na = 0; nie = 0; np = 0;
    end else begin
      case (idu_op)
        3'd1: na = int'(load_val);
        3'd2: begin nw = (m_addr == 65535); na = (m_addr + 1) % 65536; end
        3'd3: begin nw = (m_addr == 0); na = (m_addr + 65535) % 65536; end
        3'd4: begin
          nw = ((m_addr % 256) == 255);
          na = (m_addr / 256) * 256 + ((m_addr % 256) + 1) % 256;
        end
        3'd5: begin
          nw = ((m_addr % 256) == 0);
          na = (m_addr / 256) * 256 + ((m_addr % 256) + 255) % 256;
        end
        3'd6: begin
          hi = m_addr / 256;
          d = 0;
          if (alu_carry && !temp_sign) d = 1;
          if (!alu_carry && temp_sign) d = 255;
          nh = (hi + d) % 256;
          nw = (hi == 255 && nh == 0) || (hi == 0 && nh == 255);
          na = nh * 256 + int'(load_val) % 256;
        end
        default: ;
      endcase
      if (bus_wr && bus_addr == 16'hFFFF) nie = int'(bus_data);
    end
    @(posedge CLK);
    #1;
    m_addr = na;
    m_wrap = nw;
    m_ie   = nie;
    m_pend = np;
    m_any  = (np != 0);
    @(negedge CLK);
  endtask

  task automatic op(input logic [2:0] o, input logic [15:0] lv,
                    input bit c = 1'b0, input bit s = 1'b0);
    idu_op    = o;
    load_val  = lv;
    alu_carry = c;
    temp_sign = s;
    cyc();
    bus_wr = 1'b0;
  endtask

  task automatic bus(input logic [15:0] a, input logic [7:0] d);
    bus_addr = a;
    bus_data = d;
    bus_wr   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    nRESET = 1'b0;
    bus(16'hFFFF, 8'h55);
    if_in = 5'b11111;
    op(3'd1, 16'h1234);
    mon_en = 1'b1;
    bus(16'hFFFF, 8'h55);
    op(3'd1, 16'h1234);
    chk("rst_addr", int'(addr), 0);
    chk("rst_ie", int'(ie), 0);
    bus(16'hFFFF, 8'h55);
    op(3'd1, 16'h1234);
    chk("rst_pend", int'(irq_pending), 0);
    nRESET = 1'b1;
    if_in = 5'b00000;
    op(3'd0, 16'h1234);
    chk("post_rst_addr", int'(addr), 0);

    op(3'd1, 16'h00FF);
    op(3'd2, 16'h0000);
    chk("inc_carry", int'(addr), 16'h0100);
    chk("inc_carry_wrap", int'(wrap), 0);
    op(3'd1, 16'hFFFF);
    op(3'd2, 16'h0000);
    chk("inc_wrap_addr", int'(addr), 0);
    chk("inc_wrap", int'(wrap), 1);
    op(3'd0, 16'h0000);
    chk("wrap_pulse", int'(wrap), 0);
    op(3'd1, 16'h0000);
    op(3'd3, 16'h0000);
    chk("dec_wrap_addr", int'(addr), 16'hFFFF);
    chk("dec_wrap", int'(wrap), 1);

    op(3'd1, 16'h12FF);
    op(3'd4, 16'h0000);
    chk("inc_lo", int'(addr), 16'h1200);
    chk("inc_lo_wrap", int'(wrap), 1);
    op(3'd5, 16'h0000);
    chk("dec_lo", int'(addr), 16'h12FF);
    chk("dec_lo_wrap", int'(wrap), 1);

    op(3'd1, 16'h1280);
    op(3'd6, 16'h0010, 1'b1, 1'b0);
    chk("adj_up", int'(addr), 16'h1310);
    op(3'd1, 16'h1280);
    op(3'd6, 16'h0010, 1'b0, 1'b1);
    chk("adj_dn", int'(addr), 16'h1110);
    op(3'd1, 16'h1280);
    op(3'd6, 16'h0010, 1'b1, 1'b1);
    chk("adj_keep", int'(addr), 16'h1210);
    op(3'd1, 16'hFF80);
    op(3'd6, 16'h0010, 1'b1, 1'b0);
    chk("adj_wrap_addr", int'(addr), 16'h0010);
    chk("adj_wrap", int'(wrap), 1);
    op(3'd1, 16'h0080);
    op(3'd6, 16'h0033, 1'b0, 1'b1);
    chk("adj_wrap_dn", int'(addr), 16'hFF33);
    op(3'd7, 16'h4444);
    chk("op7_hold", int'(addr), 16'hFF33);

    if_in = 5'b00101;
    bus(16'hFFFF, 8'h1F);
    op(3'd0, 16'h0000);
    chk("ie_wr", int'(ie), 8'h1F);
    chk("ie_pend_lat", int'(irq_pending), 0);
    bus(16'hFFFE, 8'hAA);
    op(3'd0, 16'h0000);
    chk("ie_other_addr", int'(ie), 8'h1F);
    chk("pend", int'(irq_pending), 5'b00101);
    chk("any", int'(irq_any), 1);

    op(3'd1, 16'h0041);
    bus(16'hFFFF, 8'h01);
    op(3'd2, 16'h0000);
    chk("conc_ie", int'(ie), 8'h01);
    chk("conc_addr", int'(addr), 16'h0042);
    chk("conc_pend_old", int'(irq_pending), 5'b00101);
    op(3'd0, 16'h0000);
    chk("conc_pend_new", int'(irq_pending), 5'b00001);

    for (int i = 0; i < 60; i++) begin
      nRESET = ($urandom_range(0, 15) != 0);
      if_in = 5'($urandom);
      if ($urandom_range(0, 2) == 0)
        bus(($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom), 8'($urandom));
      op(3'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    nRESET = 1'b1;
    op(3'd0, 16'h0000);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idu_ie_ctrl.md
# idu_ie_ctrl

Parametrised, registered successor of the combinational IDU/IE control strobe logic. It holds the address register driven onto the address bus, applies pairwise, low-half-only or sign/carry-directed relative-jump adjustments to that register, and owns the interrupt-enable (IE) register with its bus-mapped write decode. It also produces the registered pending-interrupt vector (IE & IF) for the IRQ arbiter.

## Interface
Parameters:
- ADDR_W, 16, address register width; must be even.
- HALF_W, ADDR_W/2, width of each inc/dec half.
- DATA_W, 8, data bus width and IE register width.
- N_IRQ, 5, number of interrupt sources; N_IRQ ≤ DATA_W.
- IE_ADDR, 16'hFFFF, bus address that selects IE.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- nRESET  in  1  reset, synchronous, active-low.
- idu_op  in  3  operation code (see Operation).
- load_val  in  ADDR_W  value for LOAD; low half is also used by ADJ.
- alu_carry  in  1  carry from the ALU low-half add (ADJ only).
- temp_sign  in  1  sign bit of the temp Z operand (Z[7]) (ADJ only).
- addr  out  ADDR_W  current address register.
- wrap  out  1  one-cycle pulse: the last operation wrapped.
- bus_addr  in  ADDR_W  CPU bus address.
- bus_wr  in  1  bus write strobe.
- bus_data  in  DATA_W  bus write data.
- ie  out  DATA_W  IE register.
- if_in  in  N_IRQ  interrupt request flags.
- irq_pending  out  N_IRQ  registered (ie & if_in).
- irq_any  out  1  OR-reduction of irq_pending.

## Operation
- idu_op encodings:
  - 0 HOLD
  - 1 LOAD: addr ← load_val.
  - 2 INC: full ADDR_W +1, carry crosses halves.
  - 3 DEC: full ADDR_W −1.
  - 4 INC_LO: low half +1, high half unchanged.
  - 5 DEC_LO: low half −1, high half unchanged.
  - 6 ADJ: low ← load_val low half; high ← high+1 if alu_carry & ~temp_sign, high−1 if ~alu_carry & temp_sign, otherwise unchanged.
  - 7: reserved, behaves as HOLD.
- Arithmetic is modulo 2^ADDR_W for INC/DEC and modulo 2^HALF_W per half for INC_LO/DEC_LO/ADJ.
- wrap is set for one cycle on the following events, and is 0 otherwise (including for LOAD and HOLD):
  - INC from all-ones; DEC from zero.
  - INC_LO from low=all-ones; DEC_LO from low=0.
  - ADJ whose high half goes all-ones→0 or 0→all-ones.
- IE write: when bus_wr=1 and bus_addr==IE_ADDR, ie ← bus_data at the edge. No other address affects ie. All DATA_W bits are stored and readable.
- irq_pending ← ie[N_IRQ-1:0] & if_in every cycle. The AND uses the pre-edge ie value.
- irq_any ← |(ie[N_IRQ-1:0] & if_in), registered in the same cycle as irq_pending.
- The IDU path and the IE path are independent. Any idu_op may coincide with an IE write; both take effect.
- Reset (nRESET=0 at the edge) overrides all operations and writes. Reset values: addr=0, wrap=0, ie=0, irq_pending=0, irq_any=0. An operation presented in a reset cycle is discarded, not deferred.

## Timing
- Every output is a flop; there are no combinational input→output paths.
- addr/wrap: 1-cycle latency from idu_op. Back-to-back ops each see the previous result.
- ie: visible the cycle after the write edge.
- irq_pending follows if_in with 1-cycle latency, and follows an IE write with 2-cycle latency (write edge, then AND edge).
- No handshake and no stall: an op is accepted every cycle.

## Structure
- Shared package sm83_idu_pkg holds:
  - op-code constants (IDU_HOLD…IDU_ADJ);
  - the reset value constants;
  - the default IE_ADDR.
- Sub-module idu_half (HALF_W-bit registered half with inc/dec/load, carry-in/borrow-in, and wrap out), instantiated twice. The top level chains the carry for INC/DEC, breaks the chain for the _LO ops, and drives the high half's direction from alu_carry/temp_sign for ADJ.
- IE register, write decode and pending logic sit in the top level.

## Test plan
- Reset: hold nRESET=0 with idu_op=LOAD, load_val=16'h1234 → addr=0, ie=0, irq_pending=0 for every reset cycle, and one cycle after release.
- Carry chain: LOAD 16'h00FF then INC → addr=16'h0100, wrap=0. LOAD 16'hFFFF then INC → addr=16'h0000, wrap=1 for one cycle. LOAD 16'h0000 then DEC → addr=16'hFFFF, wrap=1.
- Low-half ops: LOAD 16'h12FF then INC_LO → addr=16'h1200, wrap=1. From 16'h1200, DEC_LO → addr=16'h12FF, wrap=1.
- ADJ, with addr=16'h1280:
  - load_val=16'h0010, alu_carry=1, temp_sign=0 → addr=16'h1310.
  - alu_carry=0, temp_sign=1 → addr=16'h1110.
  - alu_carry=1, temp_sign=1 → addr=16'h1210.
  - Starting from addr=16'hFF80 with alu_carry=1, temp_sign=0 → high half wraps to 8'h00, wrap=1.
- IE decode:
  - Write 8'h1F at 16'hFFFF → ie=8'h1F next cycle.
  - Write 8'hAA at 16'hFFFE → ie unchanged.
  - With if_in=5'b00101 → irq_pending=5'b00101 and irq_any=1 two cycles after the write.
- Concurrency: in the same cycle, IE write 8'h01 and idu_op=INC from 16'h0041 → next cycle ie=8'h01 and addr=16'h0042. In that same next cycle irq_pending still reflects the old ie.
